pipe_stall_ctrl: RTL and testbench

- Responder side of the hazard-detection interface. Consumes the load-use stall request from the hazard unit, the taken-branch/jump resolution from the EX/MEM stage, and the divide-start pulse from EX.
- Drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX and EX/MEM.
- Owns the IF/ID pipeline register and a multi-cycle divide-wait FSM.
- Sits between the hazard unit, the branch logic and the 5-stage Minisys-1A datapath.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stall_ctrl_if.sv | 42 ++++
 rtl/pipe_stall_ctrl_if_id_reg.sv | 34 +++
 rtl/pipe_stall_ctrl.sv | 109 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the FSM state encoding, the NOP encoding and the default divide latency.
package pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      DIV_WAIT = 1'b1
   } state_t;

   localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
   localparam int          DIV_CYCLES_DEF = 32;

   // Width of the divide-wait down-counter; it must hold DIV_CYCLES-2.
   function automatic int div_cnt_width(input int div_cycles);
      return (div_cycles > 2) ? $clog2(div_cycles) : 1;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle between the hazard unit / branch logic / datapath (master) and the
// stall controller (slave).
interface pipe_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   import pipe_pkg::*;

   // Enable semantics: a stage register loads on a clock edge only while its
   // *_write is 1; a *_bubble of 1 makes that register load a NOP instead of
   // the upstream stage. Stall and flush requests are level signals, sampled
   // every rising edge; ex_div_start is a one-cycle pulse.
   logic              ld_use_stall;
   logic              ex_mem_branch_taken;
   logic              ex_div_start;
   logic [31:0]       if_pc_plus4;
   logic [31:0]       if_instr;

   logic              pc_write;
   logic              if_id_write;
   logic              id_ex_bubble;
   logic              id_ex_write;
   logic              ex_mem_bubble;
   logic [31:0]       id_pc_plus4;
   logic [31:0]       id_instr;
   logic              id_valid;
   logic              div_busy;
   logic [CNT_W-1:0]  stall_cycles;
   state_t            state;

   modport master (
      output ld_use_stall, ex_mem_branch_taken, ex_div_start, if_pc_plus4, if_instr,
      input  pc_write, if_id_write, id_ex_bubble, id_ex_write, ex_mem_bubble,
      input  id_pc_plus4, id_instr, id_valid, div_busy, stall_cycles, state
   );

   modport slave (
      input  ld_use_stall, ex_mem_branch_taken, ex_div_start, if_pc_plus4, if_instr,
      output pc_write, if_id_write, id_ex_bubble, id_ex_write, ex_mem_bubble,
      output id_pc_plus4, id_instr, id_valid, div_busy, stall_cycles, state
   );

endinterface

// File: rtl/pipe_stall_ctrl_if_id_reg.sv
// IF/ID pipeline register: PC+4, instruction and a valid bit.
// A flush wins over a write and leaves a NOP with valid cleared.
module if_id_reg
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] src_pc_plus4,
   input  logic [31:0] src_instr,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_plus4 <= 32'h0;
         instr    <= NOP_INSTR;
         valid    <= 1'b0;
      end else if (flush) begin
         // PC+4 still follows IF so the slot keeps a sensible address.
         pc_plus4 <= src_pc_plus4;
         instr    <= NOP_INSTR;
         valid    <= 1'b0;
      end else if (load) begin
         pc_plus4 <= src_pc_plus4;
         instr    <= src_instr;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: owns IF/ID, the divide-wait
// FSM and a saturating count of cycles in which the PC did not advance.
module pipe_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   pipe_stall_ctrl_if.slave  bus
);

   localparam int                DCNT_W   = div_cnt_width(DIV_CYCLES);
   localparam logic [DCNT_W-1:0] DIV_LOAD = DCNT_W'(DIV_CYCLES - 2);

   state_t             state;
   state_t             state_next;
   logic [DCNT_W-1:0]  div_cnt;
   logic [DCNT_W-1:0]  div_cnt_next;
   logic [CNT_W-1:0]   stall_cnt;

   logic               pc_write;
   logic               if_id_write;
   logic               id_ex_bubble;
   logic               id_ex_write;
   logic               ex_mem_bubble;
   logic               if_id_flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         div_cnt <= '0;
      end else begin
         state   <= state_next;
         div_cnt <= div_cnt_next;
      end
   end

   // Priority: reset > branch flush > divide hold > load-use stall > normal.
   always_comb begin
      state_next    = state;
      div_cnt_next  = div_cnt;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      if_id_flush   = 1'b0;
      if (!reset) begin
         if (bus.ex_mem_branch_taken) begin
            // A divide starting alongside the flush is on the wrong path.
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            state_next    = RUN;
            div_cnt_next  = '0;
         end else if (state == DIV_WAIT) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            if (div_cnt == '0) begin
               state_next = RUN;
            end else begin
               div_cnt_next = div_cnt - DCNT_W'(1);
            end
         end else if (bus.ex_div_start) begin
            // The start cycle itself counts toward EX occupancy.
            state_next   = DIV_WAIT;
            div_cnt_next = DIV_LOAD;
         end else if (bus.ld_use_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (!pc_write && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   if_id_reg u_if_id (
      .clk          (clk),
      .reset        (reset),
      .load         (if_id_write),
      .flush        (if_id_flush),
      .src_pc_plus4 (bus.if_pc_plus4),
      .src_instr    (bus.if_instr),
      .pc_plus4     (bus.id_pc_plus4),
      .instr        (bus.id_instr),
      .valid        (bus.id_valid)
   );

   assign bus.pc_write      = pc_write;
   assign bus.if_id_write   = if_id_write;
   assign bus.id_ex_bubble  = id_ex_bubble;
   assign bus.id_ex_write   = id_ex_write;
   assign bus.ex_mem_bubble = ex_mem_bubble;
   assign bus.div_busy      = (state == DIV_WAIT);
   assign bus.stall_cycles  = stall_cnt;
   assign bus.state         = state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic, all
// checked against a cycle-level reference model of the stall/flush rules.
module tb_pipe_stall_ctrl;
   import pipe_pkg::*;

   localparam int DIV_CYCLES = 4;
   localparam int CNT_W      = 4;
   localparam int SAT        = (1 << CNT_W) - 1;
   localparam int W          = 65;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: IF/ID contents, remaining divide hold cycles, stall count.
   logic [31:0]   m_pc;
   logic [31:0]   m_instr;
   logic          m_valid;
   int            m_hold;
   int            m_stalls;
   logic [W-1:0]  exp_q[$];

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc     = 32'h0;
      m_instr  = NOP_INSTR;
      m_valid  = 1'b0;
      m_hold   = 0;
      m_stalls = 0;
      exp_q.delete();
      exp_q.push_back({m_valid, m_pc, m_instr});
   endtask

   task automatic step(input bit r, input bit br, input bit dv, input bit ld,
                       input logic [31:0] pc, input logic [31:0] ins);
      bit e_pcw, e_ifw, e_idw, e_idb, e_exb, e_busy;
      @(negedge clk);
      reset                   = r;
      bus.ex_mem_branch_taken = br;
      bus.ex_div_start        = dv;
      bus.ld_use_stall        = ld;
      bus.if_pc_plus4         = pc;
      bus.if_instr            = ins;
      #2;
      e_busy = (m_hold > 0);
      {e_pcw, e_ifw, e_idw, e_idb, e_exb} = 5'b11100;
      if (r) begin
         {e_pcw, e_ifw, e_idw, e_idb, e_exb} = 5'b11100;
      end else if (br) begin
         {e_pcw, e_ifw, e_idw, e_idb, e_exb} = 5'b11111;
      end else if (m_hold > 0) begin
         {e_pcw, e_ifw, e_idw, e_idb, e_exb} = 5'b00001;
      end else if (ld && !dv) begin
         {e_pcw, e_ifw, e_idw, e_idb, e_exb} = 5'b00110;
      end
      check_eq("pc_write",      W'(bus.pc_write),      W'(e_pcw));
      check_eq("if_id_write",   W'(bus.if_id_write),   W'(e_ifw));
      check_eq("id_ex_write",   W'(bus.id_ex_write),   W'(e_idw));
      check_eq("id_ex_bubble",  W'(bus.id_ex_bubble),  W'(e_idb));
      check_eq("ex_mem_bubble", W'(bus.ex_mem_bubble), W'(e_exb));
      check_eq("div_busy",      W'(bus.div_busy),      W'(e_busy));
      check_eq("state",         W'(bus.state),         W'(e_busy));
      check_eq("stall_cycles",  W'(bus.stall_cycles),  W'(m_stalls));
      if (exp_q.size() > 0)
         check_eq("if_id", {bus.id_valid, bus.id_pc_plus4, bus.id_instr}, exp_q.pop_front());
      if (r) begin
         model_reset();
         void'(exp_q.pop_front());
      end else begin
         if (!e_pcw && m_stalls < SAT) m_stalls++;
         if (br) begin
            m_pc = pc; m_instr = NOP_INSTR; m_valid = 1'b0; m_hold = 0;
         end else if (m_hold > 0) begin
            m_hold--;
         end else if (dv) begin
            m_pc = pc; m_instr = ins; m_valid = 1'b1; m_hold = DIV_CYCLES - 1;
         end else if (!ld) begin
            m_pc = pc; m_instr = ins; m_valid = 1'b1;
         end
      end
      exp_q.push_back({m_valid, m_pc, m_instr});
   endtask

   task automatic post_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset                   = 1'b1;
      bus.ex_mem_branch_taken = 1'b0;
      bus.ex_div_start        = 1'b0;
      bus.ld_use_stall        = 1'b0;
      bus.if_pc_plus4         = 32'h0;
      bus.if_instr            = 32'h0;
      @(posedge clk);
      #1;
      model_reset();
      check_eq("rst_valid",  W'(bus.id_valid),     W'(0));
      check_eq("rst_instr",  W'(bus.id_instr),     W'(0));
      check_eq("rst_stalls", W'(bus.stall_cycles), W'(0));
      check_eq("rst_pcw",    W'(bus.pc_write),     W'(1));

      // Load-use stall with a load already in IF/ID.
      step(1, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 0, 32'h0000_0008, 32'h8C22_0004);
      post_edge();
      bus.ld_use_stall = 1'b1;
      #1;
      check_eq("lu_pcw",    W'(bus.pc_write),     W'(0));
      check_eq("lu_ifw",    W'(bus.if_id_write),  W'(0));
      check_eq("lu_bubble", W'(bus.id_ex_bubble), W'(1));
      step(0, 0, 0, 1, 32'h0000_000C, 32'h0043_1820);
      post_edge();
      check_eq("lu_hold_instr", W'(bus.id_instr),     W'(32'h8C22_0004));
      check_eq("lu_stalls",     W'(bus.stall_cycles), W'(1));

      // Divide: three hold cycles after the start cycle.
      step(1, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 0, 32'h0000_0004, 32'h0085_001A);
      step(0, 0, 1, 0, 32'h0000_0008, 32'h0000_0000);
      for (int i = 0; i < DIV_CYCLES - 1; i++) begin
         post_edge();
         check_eq("div_busy_on", W'(bus.div_busy),      W'(1));
         check_eq("div_pcw",     W'(bus.pc_write),      W'(0));
         check_eq("div_exb",     W'(bus.ex_mem_bubble), W'(1));
         step(0, 0, 0, 0, 32'h0000_000C, 32'h0000_0000);
      end
      post_edge();
      check_eq("div_done_busy", W'(bus.div_busy),     W'(0));
      check_eq("div_done_pcw",  W'(bus.pc_write),     W'(1));
      check_eq("div_stalls",    W'(bus.stall_cycles), W'(3));

      // Reset in the third cycle after the divide start.
      step(1, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 0, 32'h0000_0004, 32'h1111_2222);
      step(0, 0, 1, 0, 32'h0000_0008, 32'h0);
      step(0, 0, 0, 0, 32'h0000_000C, 32'h0);
      step(0, 0, 0, 0, 32'h0000_000C, 32'h0);
      step(1, 0, 0, 0, 32'h0000_000C, 32'h0);
      post_edge();
      check_eq("mrst_state",  W'(bus.state),        W'(RUN));
      check_eq("mrst_valid",  W'(bus.id_valid),     W'(0));
      check_eq("mrst_instr",  W'(bus.id_instr),     W'(0));
      check_eq("mrst_stalls", W'(bus.stall_cycles), W'(0));
      check_eq("mrst_pcw",    W'(bus.pc_write),     W'(1));

      // Branch in the second divide wait cycle.
      step(0, 0, 0, 0, 32'h0000_0004, 32'h3333_4444);
      step(0, 0, 1, 0, 32'h0000_0008, 32'h0);
      step(0, 0, 0, 0, 32'h0000_000C, 32'h0);
      post_edge();
      bus.ex_mem_branch_taken = 1'b1;
      #1;
      check_eq("br_pcw", W'(bus.pc_write),      W'(1));
      check_eq("br_idb", W'(bus.id_ex_bubble),  W'(1));
      check_eq("br_idw", W'(bus.id_ex_write),   W'(1));
      check_eq("br_exb", W'(bus.ex_mem_bubble), W'(1));
      step(0, 1, 0, 0, 32'h0000_0040, 32'h5555_6666);
      post_edge();
      check_eq("br_valid", W'(bus.id_valid), W'(0));
      check_eq("br_busy",  W'(bus.div_busy), W'(0));

      // Branch, load-use and divide start all at once in RUN.
      step(1, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 0, 32'h0000_0004, 32'h7777_8888);
      step(0, 1, 1, 1, 32'h0000_0008, 32'h9999_AAAA);
      post_edge();
      check_eq("all_state",  W'(bus.state),        W'(RUN));
      check_eq("all_stalls", W'(bus.stall_cycles), W'(0));
      check_eq("all_valid",  W'(bus.id_valid),     W'(0));

      // Stall counter saturation.
      step(1, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 32'h0000_0004, 32'h8C22_0004);
      post_edge();
      check_eq("sat_stalls", W'(bus.stall_cycles), W'(SAT));

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 59) == 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) == 0,
              $urandom, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
